// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / hazard controller.
package fwd_hazard_ctrl_pkg;

   localparam int unsigned REG_AW_DEF = 5;

   // Forward-select encodings seen by the ALU operand muxes.
   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD_USE = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the forwarding / hazard controller.
interface fwd_hazard_ctrl_if
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF,
   parameter int unsigned CNT_W  = 16
);
   logic [REG_AW-1:0] ifid_rs_i;
   logic [REG_AW-1:0] ifid_rt_i;
   logic              ifid_uses_rt_i;
   logic [REG_AW-1:0] idex_rs_i;
   logic [REG_AW-1:0] idex_rt_i;
   logic              idex_memread_i;
   logic [REG_AW-1:0] exmem_rd_i;
   logic              exmem_regwrite_i;
   logic [REG_AW-1:0] memwb_rd_i;
   logic              memwb_regwrite_i;
   logic              dmem_stall_i;
   logic [1:0]        fwd_a_o;
   logic [1:0]        fwd_b_o;
   logic              pc_write_o;
   logic              ifid_write_o;
   logic              idex_bubble_o;
   logic              pipe_freeze_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic              timeout_o;

   // Pipeline side: supplies register indices and status, consumes controls.
   modport master (
      output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_rs_i, idex_rt_i,
             idex_memread_i, exmem_rd_i, exmem_regwrite_i, memwb_rd_i,
             memwb_regwrite_i, dmem_stall_i,
      input  fwd_a_o, fwd_b_o, pc_write_o, ifid_write_o, idex_bubble_o,
             pipe_freeze_o, stall_cnt_o, timeout_o
   );

   // Controller side.
   modport slave (
      input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_rs_i, idex_rt_i,
             idex_memread_i, exmem_rd_i, exmem_regwrite_i, memwb_rd_i,
             memwb_regwrite_i, dmem_stall_i,
      output fwd_a_o, fwd_b_o, pc_write_o, ifid_write_o, idex_bubble_o,
             pipe_freeze_o, stall_cnt_o, timeout_o
   );
endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Priority forward-select decision for one ALU operand.
module fwd_hazard_ctrl_fwd_sel
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic              exmem_regwrite_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic              memwb_regwrite_i,
   output logic [1:0]        sel_o
);
   // EX/MEM result is newer than MEM/WB, so it wins; r0 is never forwarded.
   always_comb begin
      sel_o = FWD_REG;
      if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i))
         sel_o = FWD_EXMEM;
      else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i))
         sel_o = FWD_MEMWB;
   end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding selects plus load-use bubble / memory-freeze sequencing.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW   = REG_AW_DEF,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_WAIT = 255
) (
   input logic             clk_i,
   input logic             rst_i,
   fwd_hazard_ctrl_if.slave bus
);
   localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   state_e            state_q, state_d;
   logic [1:0]        hold_a_q, hold_b_q;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic              timeout_q;
   logic              run_q;
   logic [1:0]        live_a, live_b, fwd_a, fwd_b;
   logic              load_use, mem_busy, bubble, pc_write;

   fwd_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .src_i            (bus.idex_rs_i),
      .exmem_rd_i       (bus.exmem_rd_i),
      .exmem_regwrite_i (bus.exmem_regwrite_i),
      .memwb_rd_i       (bus.memwb_rd_i),
      .memwb_regwrite_i (bus.memwb_regwrite_i),
      .sel_o            (live_a)
   );

   fwd_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .src_i            (bus.idex_rt_i),
      .exmem_rd_i       (bus.exmem_rd_i),
      .exmem_regwrite_i (bus.exmem_regwrite_i),
      .memwb_rd_i       (bus.memwb_rd_i),
      .memwb_regwrite_i (bus.memwb_regwrite_i),
      .sel_o            (live_b)
   );

   assign load_use = bus.idex_memread_i && (bus.idex_rt_i != '0) &&
                     ((bus.idex_rt_i == bus.ifid_rs_i) ||
                      (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));

   // Same-cycle stall/freeze decisions and next-state; memory busy beats load-use.
   // Released MEM_WAIT cycle may bubble directly so a persisting hazard never slips through.
   always_comb begin
      mem_busy = run_q & bus.dmem_stall_i;
      bubble   = run_q & ~mem_busy & load_use & (state_q != ST_LOAD_USE);
      pc_write = ~(mem_busy | bubble);
      state_d  = ST_IDLE;
      if (mem_busy)
         state_d = ST_MEM_WAIT;
      else if (bubble)
         state_d = ST_LOAD_USE;
      wait_d = '0;
      if (mem_busy)
         wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
      if (!run_q) begin
         fwd_a = FWD_REG;
         fwd_b = FWD_REG;
      end else if (state_q == ST_MEM_WAIT) begin
         fwd_a = hold_a_q;
         fwd_b = hold_b_q;
      end else begin
         fwd_a = live_a;
         fwd_b = live_b;
      end
   end

   // State, held selects, wait/stall counters and sticky timeout.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         hold_a_q    <= FWD_REG;
         hold_b_q    <= FWD_REG;
         wait_q      <= '0;
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         state_q <= state_d;
         wait_q  <= wait_d;
         if (mem_busy && (state_q != ST_MEM_WAIT)) begin
            hold_a_q <= live_a;
            hold_b_q <= live_b;
         end
         if (mem_busy && (wait_d == WAIT_MAX))
            timeout_q <= 1'b1;
         if (!pc_write && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign bus.fwd_a_o       = fwd_a;
   assign bus.fwd_b_o       = fwd_b;
   assign bus.pc_write_o    = pc_write;
   assign bus.ifid_write_o  = pc_write;
   assign bus.idex_bubble_o = bubble;
   assign bus.pipe_freeze_o = mem_busy;
   assign bus.stall_cnt_o   = stall_cnt_q;
   assign bus.timeout_o     = timeout_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: driver pushes hand-computed expectations, negedge monitor checks.
module tb_fwd_hazard_ctrl;
   import fwd_hazard_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .MAX_WAIT(3)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      string       name;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        pcw;
      logic        ifw;
      logic        bub;
      logic        frz;
      logic [15:0] cnt;
      logic        to;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Normal / bubble / freeze expectation builders.
   function automatic exp_t ok(string n, logic [1:0] fa, logic [1:0] fb, int c, logic t);
      exp_t e;
      e.name = n; e.fa = fa; e.fb = fb; e.pcw = 1'b1; e.ifw = 1'b1;
      e.bub = 1'b0; e.frz = 1'b0; e.cnt = 16'(c); e.to = t;
      return e;
   endfunction

   function automatic exp_t bub(string n, logic [1:0] fa, logic [1:0] fb, int c, logic t);
      exp_t e;
      e = ok(n, fa, fb, c, t);
      e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
      return e;
   endfunction

   function automatic exp_t frz(string n, logic [1:0] fa, logic [1:0] fb, int c, logic t);
      exp_t e;
      e = ok(n, fa, fb, c, t);
      e.pcw = 1'b0; e.ifw = 1'b0; e.frz = 1'b1;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.ifid_rs_i = '0; bus.ifid_rt_i = '0; bus.ifid_uses_rt_i = 1'b0;
      bus.idex_rs_i = '0; bus.idex_rt_i = '0; bus.idex_memread_i = 1'b0;
      bus.exmem_rd_i = '0; bus.exmem_regwrite_i = 1'b0;
      bus.memwb_rd_i = '0; bus.memwb_regwrite_i = 1'b0;
      bus.dmem_stall_i = 1'b0;
   endtask

   task automatic cyc(exp_t e);
      exp_q.push_back(e);
      step();
   endtask

   task automatic do_reset();
      clr();
      rst_n = 1'b0;
      cyc(ok("rst_hold", 2'b00, 2'b00, 0, 1'b0));
      rst_n = 1'b1;
      cyc(ok("rst_release", 2'b00, 2'b00, 0, 1'b0));
   endtask

   // Monitor: one controller output sample per cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (bus.fwd_a_o !== e.fa || bus.fwd_b_o !== e.fb || bus.pc_write_o !== e.pcw ||
             bus.ifid_write_o !== e.ifw || bus.idex_bubble_o !== e.bub ||
             bus.pipe_freeze_o !== e.frz || bus.stall_cnt_o !== e.cnt || bus.timeout_o !== e.to) begin
            errors++;
            $display("FAIL %s: got fa=%b fb=%b pcw=%b ifw=%b bub=%b frz=%b cnt=%0d to=%b, want fa=%b fb=%b pcw=%b ifw=%b bub=%b frz=%b cnt=%0d to=%b",
                     e.name, bus.fwd_a_o, bus.fwd_b_o, bus.pc_write_o, bus.ifid_write_o,
                     bus.idex_bubble_o, bus.pipe_freeze_o, bus.stall_cnt_o, bus.timeout_o,
                     e.fa, e.fb, e.pcw, e.ifw, e.bub, e.frz, e.cnt, e.to);
         end
      end
   end

   initial begin
      clr();
      step();
      // Reset forces outputs even with forwarding/stall inputs active.
      bus.exmem_regwrite_i = 1'b1; bus.exmem_rd_i = 5'd8; bus.idex_rs_i = 5'd8;
      bus.dmem_stall_i = 1'b1;
      cyc(ok("reset_forced", 2'b00, 2'b00, 0, 1'b0));
      rst_n = 1'b1;
      cyc(ok("reset_until_edge", 2'b00, 2'b00, 0, 1'b0));
      bus.dmem_stall_i = 1'b0;
      cyc(ok("fwd_after_reset", 2'b10, 2'b00, 0, 1'b0));

      // Forwarding priority and r0 guard.
      bus.memwb_regwrite_i = 1'b1; bus.memwb_rd_i = 5'd8;
      cyc(ok("fwd_a_exmem_prio", 2'b10, 2'b00, 0, 1'b0));
      bus.exmem_rd_i = 5'd0;
      cyc(ok("fwd_a_memwb", 2'b01, 2'b00, 0, 1'b0));
      bus.idex_rs_i = 5'd0; bus.memwb_rd_i = 5'd0;
      cyc(ok("fwd_a_r0", 2'b00, 2'b00, 0, 1'b0));
      bus.idex_rt_i = 5'd5; bus.memwb_rd_i = 5'd5; bus.exmem_rd_i = 5'd5;
      bus.exmem_regwrite_i = 1'b0;
      cyc(ok("fwd_b_memwb", 2'b00, 2'b01, 0, 1'b0));
      bus.exmem_regwrite_i = 1'b1;
      cyc(ok("fwd_b_exmem", 2'b00, 2'b10, 0, 1'b0));

      // Load-use bubble on rs.
      clr();
      bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd9; bus.ifid_rs_i = 5'd9;
      cyc(bub("lu_bubble", 2'b00, 2'b00, 0, 1'b0));
      clr();
      cyc(ok("lu_after", 2'b00, 2'b00, 1, 1'b0));

      // rt match only counts when ID reads rt; r0 load never stalls.
      bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd9; bus.ifid_rs_i = 5'd3;
      bus.ifid_rt_i = 5'd9; bus.ifid_uses_rt_i = 1'b0;
      cyc(ok("lu_rt_unused", 2'b00, 2'b00, 1, 1'b0));
      bus.ifid_uses_rt_i = 1'b1;
      cyc(bub("lu_rt_used", 2'b00, 2'b00, 1, 1'b0));
      clr();
      cyc(ok("lu_rt_after", 2'b00, 2'b00, 2, 1'b0));
      bus.idex_memread_i = 1'b1;
      cyc(ok("lu_r0", 2'b00, 2'b00, 2, 1'b0));

      // Memory wait: 4 freeze cycles, fwd_b held while WB changes.
      do_reset();
      bus.memwb_regwrite_i = 1'b1; bus.memwb_rd_i = 5'd7; bus.idex_rt_i = 5'd7;
      cyc(ok("mw_pre", 2'b00, 2'b01, 0, 1'b0));
      bus.dmem_stall_i = 1'b1;
      cyc(frz("mw_1", 2'b00, 2'b01, 0, 1'b0));
      bus.memwb_rd_i = 5'd3;
      cyc(frz("mw_2_held", 2'b00, 2'b01, 1, 1'b0));
      cyc(frz("mw_3_held", 2'b00, 2'b01, 2, 1'b0));
      cyc(frz("mw_4_timeout", 2'b00, 2'b01, 3, 1'b1));
      bus.dmem_stall_i = 1'b0; bus.memwb_rd_i = 5'd7;
      cyc(ok("mw_release", 2'b00, 2'b01, 4, 1'b1));
      cyc(ok("mw_sticky", 2'b00, 2'b01, 4, 1'b1));

      // Load-use coincident with memory busy: freeze wins, bubble after release.
      do_reset();
      bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd9; bus.ifid_rs_i = 5'd9;
      bus.dmem_stall_i = 1'b1;
      cyc(frz("both_1", 2'b00, 2'b00, 0, 1'b0));
      cyc(frz("both_2", 2'b00, 2'b00, 1, 1'b0));
      bus.dmem_stall_i = 1'b0;
      cyc(bub("both_bubble", 2'b00, 2'b00, 2, 1'b0));
      clr();
      cyc(ok("both_cnt3", 2'b00, 2'b00, 3, 1'b0));

      // Timeout then reset in the middle of the wait.
      do_reset();
      bus.dmem_stall_i = 1'b1;
      cyc(frz("to_1", 2'b00, 2'b00, 0, 1'b0));
      cyc(frz("to_2", 2'b00, 2'b00, 1, 1'b0));
      cyc(frz("to_3", 2'b00, 2'b00, 2, 1'b0));
      cyc(frz("to_4", 2'b00, 2'b00, 3, 1'b1));
      rst_n = 1'b0;
      cyc(ok("to_mid_reset", 2'b00, 2'b00, 0, 1'b0));
      rst_n = 1'b1;
      bus.dmem_stall_i = 1'b0;
      cyc(ok("to_reset_release", 2'b00, 2'b00, 0, 1'b0));
      cyc(ok("to_cleared", 2'b00, 2'b00, 0, 1'b0));

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Pipeline controller for the EX-stage operand forwarding muxes and the hazard stall and flush sequencing of the 5-stage pipeline.
- Drives the 2-bit forward selects consumed by the ALU operand-A and operand-B forwarding muxes.
- Sequences the one-cycle load-use bubble.
- Freezes the whole pipeline while the data memory or cache reports busy.
- Keeps a saturating stall-cycle counter and a memory-wait timeout flag.

Parameters:
REG_AW, 5, register-index width
CNT_W, 16, stall counter width
MAX_WAIT, 255, memory-wait cycles before timeout_o asserts

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
ifid_rs_i  in  REG_AW  rs of instruction in ID
ifid_rt_i  in  REG_AW  rt of instruction in ID
ifid_uses_rt_i  in  1  ID instruction reads rt
idex_rs_i  in  REG_AW  rs in EX
idex_rt_i  in  REG_AW  rt in EX
idex_memread_i  in  1  EX instruction is a load
exmem_rd_i  in  REG_AW  destination in MEM
exmem_regwrite_i  in  1  MEM writes register
memwb_rd_i  in  REG_AW  destination in WB
memwb_regwrite_i  in  1  WB writes register
dmem_stall_i  in  1  data memory busy
fwd_a_o  out  2  operand-A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b_o  out  2  operand-B select, same encoding
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register enable
idex_bubble_o  out  1  zero ID/EX control fields
pipe_freeze_o  out  1  hold every pipeline register
stall_cnt_o  out  CNT_W  total stall cycles, saturating
timeout_o  out  1  sticky: memory wait exceeded MAX_WAIT

Behaviour:
- Reset (rst_i low, asynchronous) forces the following until the next clock edge after release:
  - state IDLE
  - fwd_a_o=fwd_b_o=00
  - pc_write_o=ifid_write_o=1
  - idex_bubble_o=0, pipe_freeze_o=0
  - stall_cnt_o=0, timeout_o=0, wait counter=0
- Forwarding decision, combinational, for operand X with source register s (rs for A, rt for B):
  - 10 if exmem_regwrite_i && exmem_rd_i!=0 && exmem_rd_i==s.
  - Otherwise 01 if memwb_regwrite_i && memwb_rd_i!=0 && memwb_rd_i==s.
  - Otherwise 00.
  - EX/MEM has priority. Encoding 11 is never driven.
- Load-use hazard: idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || (ifid_uses_rt_i && idex_rt_i==ifid_rt_i)).
- FSM states are IDLE, LOAD_USE and MEM_WAIT. The MEM_WAIT test is checked before the load-use test in every state.
- IDLE:
  - Outputs: forwarding outputs are the live decision; pc_write_o and ifid_write_o are 1.
  - If dmem_stall_i=1, go to MEM_WAIT. In that same cycle pipe_freeze_o=1, pc_write_o=ifid_write_o=0, and the current fwd selects are captured into hold registers.
  - Else, if load-use, go to LOAD_USE. In that same cycle pc_write_o=ifid_write_o=0 and idex_bubble_o=1.
- LOAD_USE:
  - Lasts exactly one cycle. Outputs return to normal and the forwarding outputs are live.
  - Next state is IDLE, or MEM_WAIT if dmem_stall_i=1.
  - The load is now in MEM, so the dependent instruction receives EX/MEM or MEM/WB forwarding on later cycles.
- MEM_WAIT:
  - Outputs: pipe_freeze_o=1, pc_write_o=ifid_write_o=0, idex_bubble_o=0. fwd_a_o and fwd_b_o output the held values, not the live decision, because WB contents may change under freeze.
  - The wait counter increments each cycle. When it reaches MAX_WAIT, timeout_o sets and stays set until reset.
  - When dmem_stall_i falls, return to IDLE and clear the wait counter. Load-use is re-evaluated in IDLE on frozen-then-released inputs.
- Stall and freeze outputs are combinational from state and inputs: zero added latency, as the surrounding registers require same-cycle enables.
- stall_cnt_o increments by 1 on every clock where pc_write_o=0, and saturates at all-ones.
- If load-use and dmem_stall_i occur in the same cycle, MEM_WAIT wins and no bubble is inserted that cycle. The bubble is inserted after release if the hazard persists.
- If reset asserts in the middle of MEM_WAIT, state, hold registers and counters clear immediately.

Decomposition:
- Shared package:
  - forward-select localparams FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - FSM state encoding
  - REG_AW default
- Sub-module fwd_sel: the combinational priority compare for one operand, instantiated twice (operand A and operand B).

Test Plan:
- exmem_regwrite=1, exmem_rd=8, memwb_regwrite=1, memwb_rd=8, idex_rs=8 -> fwd_a_o=10 (EX/MEM priority); set exmem_rd=0 with memwb_rd=8 -> 01; set idex_rs=0 with rd=0 -> 00.
- idex_memread=1, idex_rt=9, ifid_rs=9 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1, then normal; stall_cnt=1.
- ifid_rt=9 with ifid_uses_rt=0 in the load-use setup -> no stall.
- dmem_stall_i high for 4 cycles while fwd_b_o=01 and memwb_rd is changed mid-wait -> pipe_freeze=1 for 4 cycles, fwd_b_o held at 01, stall_cnt=4, then release.
- Load-use and dmem_stall_i together for 2 cycles -> 2 freeze cycles, then 1 bubble cycle; stall_cnt=3.
- MAX_WAIT=3 and dmem_stall_i held 5 cycles -> timeout_o rises after the 3rd wait cycle and stays 1 after release; asserting rst_i mid-wait clears it.
